queue_ptr_manager: RTL

QUEUE_PTR_MANAGER -- requirements
Module: queue_ptr_manager

---
 rtl/queue_ptr_manager.sv | 130 +++++++++++++
 1 files changed

// File: rtl/queue_ptr_manager.sv
// Head/tail tag manager for a multi-port circular queue or free list.
// Tags are {wrap flag, index}; counters track free and occupied entries.
module queue_ptr_manager #(
  parameter int ENTRY_COUNT  = 8,
  parameter int ENQ_WIDTH    = 2,
  parameter int DEQ_WIDTH    = 2,
  parameter bit INIT_IS_FULL = 1'b0,
  localparam int PTR_W = $clog2(ENTRY_COUNT),
  localparam int TAG_W = PTR_W + 1,
  localparam int CNT_W = $clog2(ENTRY_COUNT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ENQ_WIDTH-1:0]       enq_fire_i,
  input  logic [DEQ_WIDTH-1:0]       deq_fire_i,
  input  logic                       flush_i,
  input  logic                       recover_i,
  input  logic [TAG_W-1:0]           recover_tail_i,
  output logic [DEQ_WIDTH*TAG_W-1:0] head_o,
  output logic [ENQ_WIDTH*TAG_W-1:0] tail_o,
  output logic [ENQ_WIDTH-1:0]       enq_rdy_o,
  output logic [DEQ_WIDTH-1:0]       deq_vld_o,
  output logic [CNT_W-1:0]           avail_cnt_o,
  output logic [CNT_W-1:0]           used_cnt_o,
  output logic                       err_o
);

  localparam logic [TAG_W-1:0] TAIL_RST  = INIT_IS_FULL ? {1'b1, {PTR_W{1'b0}}} : '0;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ENTRY_COUNT);
  localparam logic [CNT_W-1:0] AVAIL_RST = INIT_IS_FULL ? '0 : FULL_CNT;

  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] avail_q, avail_d, used_q, used_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] enq_cnt, deq_cnt, enq_eff, deq_eff;
  logic             enq_ok, deq_ok, rec_ok;
  int               rec_dist;

  function automatic logic [TAG_W-1:0] ptr_add(input logic [TAG_W-1:0] tag,
                                               input logic [CNT_W-1:0] n);
    int   s;
    logic flag;
    s    = int'(tag[PTR_W-1:0]) + int'(n);
    flag = tag[PTR_W];
    if (s >= ENTRY_COUNT) begin
      s    = s - ENTRY_COUNT;
      flag = ~flag;
    end
    return {flag, PTR_W'(s)};
  endfunction

  // Negative result means the tail sits behind the head: never a valid span.
  function automatic int distance(input logic [TAG_W-1:0] h, input logic [TAG_W-1:0] t);
    if (h[PTR_W] == t[PTR_W]) return int'(t[PTR_W-1:0]) - int'(h[PTR_W-1:0]);
    return ENTRY_COUNT - int'(h[PTR_W-1:0]) + int'(t[PTR_W-1:0]);
  endfunction

  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      tail_o[i*TAG_W +: TAG_W] = ptr_add(tail_q, enq_cnt);
      enq_cnt = enq_cnt + CNT_W'(enq_fire_i[i]);
      enq_rdy_o[i] = int'(avail_q) > i;
    end
    deq_cnt = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      head_o[i*TAG_W +: TAG_W] = ptr_add(head_q, deq_cnt);
      deq_cnt = deq_cnt + CNT_W'(deq_fire_i[i]);
      deq_vld_o[i] = int'(used_q) > i;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    head_d   = head_q;
    tail_d   = tail_q;
    avail_d  = avail_q;
    err_d    = err_q;
    enq_ok   = enq_cnt <= avail_q;
    deq_ok   = deq_cnt <= used_q;
    enq_eff  = enq_ok ? enq_cnt : '0;
    deq_eff  = deq_ok ? deq_cnt : '0;
    rec_dist = distance(head_q, recover_tail_i);
    rec_ok   = (int'(recover_tail_i[PTR_W-1:0]) < ENTRY_COUNT) &&
               (rec_dist >= 0) && (rec_dist <= int'(used_q));

    if (flush_i) begin
      tail_d  = INIT_IS_FULL ? {~head_q[PTR_W], head_q[PTR_W-1:0]} : head_q;
      avail_d = AVAIL_RST;
    end else if (recover_i) begin
      head_d = ptr_add(head_q, deq_eff);
      err_d  = err_q | ~deq_ok | ~rec_ok;
      if (rec_ok) begin
        tail_d  = recover_tail_i;
        avail_d = CNT_W'(ENTRY_COUNT - distance(head_d, recover_tail_i));
      end else begin
        avail_d = avail_q + deq_eff;
      end
    end else begin
      // Overflow and underflow are judged independently; no dequeue-to-enqueue bypass.
      head_d  = ptr_add(head_q, deq_eff);
      tail_d  = ptr_add(tail_q, enq_eff);
      avail_d = avail_q + deq_eff - enq_eff;
      err_d   = err_q | ~enq_ok | ~deq_ok;
    end
    used_d = FULL_CNT - avail_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= TAIL_RST;
      avail_q <= AVAIL_RST;
      used_q  <= FULL_CNT - AVAIL_RST;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      avail_q <= avail_d;
      used_q  <= used_d;
      err_q   <= err_d;
    end
  end

  assign avail_cnt_o = avail_q;
  assign used_cnt_o  = used_q;
  assign err_o       = err_q;

endmodule
